// File: rtl/count_pkg.sv
// Shared types for count_tracker: FSM state encoding, step classes and event codes.
package count_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    HOLD = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DOWN = 2'b10,
    STEP_JUMP = 2'b11
  } step_t;

  localparam logic [1:0] EVT_WRAP_UP    = 2'b00;
  localparam logic [1:0] EVT_WRAP_DOWN  = 2'b01;
  localparam logic [1:0] EVT_DIR_CHANGE = 2'b10;
  localparam logic [1:0] EVT_JUMP       = 2'b11;

endpackage

// File: rtl/count_step_classify.sv
// Combinational classifier: compares the previous and current counter samples
// and reports the step class plus wrap-around flags.
module count_step_classify
  import count_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count,
  output logic [1:0]       step,
  output logic             wrap_up,
  output logic             wrap_down
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TOP = '1;

  logic [WIDTH-1:0] delta;

  // Modular difference: +1 and -1 (all ones) are single steps in either direction.
  assign delta = count - prev;

  always_comb begin
    step = STEP_JUMP;
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == ONE) begin
      step = STEP_UP;
    end else if (delta == TOP) begin
      step = STEP_DOWN;
    end
  end

  assign wrap_up   = (prev == TOP) && (count == '0);
  assign wrap_down = (prev == '0)  && (count == TOP);

endmodule

// File: rtl/count_tracker.sv
// Tracks an up/down counter, classifies each step and emits wrap, direction
// change and (with COUNT_TRACKER_JUMP_CHECK_EN defined) jump events.
module count_tracker
  import count_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_code,
  output logic [WRAP_W-1:0] evt_wraps,
  output logic [1:0]        dir,
  output logic              overflow
);

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    prev;
  logic                prev_valid;
  logic                last_dir_valid;
  logic                last_dir_down;
  logic [WRAP_W-1:0]   wraps;
  logic [WRAP_W-1:0]   wraps_next;
  logic [1:0]          step_raw;
  logic [1:0]          step_eff;
  logic                wrap_up;
  logic                wrap_down;
  logic                classify;
  logic                is_up;
  logic                is_down;
  logic                is_jump;
  logic                dir_change;
  logic                new_evt;
  logic [1:0]          new_code;
  logic                load;

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev      (prev),
    .count     (count),
    .step      (step_raw),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down)
  );

`ifdef COUNT_TRACKER_JUMP_CHECK_EN
  assign step_eff = step_raw;
`else
  assign step_eff = (step_raw == STEP_JUMP) ? STEP_HOLD : step_raw;
`endif

  // prev is meaningless until one real sample has been captured after reset.
  assign classify   = prev_valid;
  assign is_up      = (step_eff == STEP_UP);
  assign is_down    = (step_eff == STEP_DOWN);
  assign is_jump    = (step_eff == STEP_JUMP);
  assign dir_change = last_dir_valid && ((is_up && last_dir_down) || (is_down && !last_dir_down));
  assign wraps_next = wraps + WRAP_W'(classify && (wrap_up || wrap_down));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (classify) begin
      case (step_eff)
        STEP_UP:   state_next = UP;
        STEP_DOWN: state_next = DOWN;
        STEP_HOLD: state_next = HOLD;
        default:   state_next = state;
      endcase
    end
  end

  // Event selection; SYNC only establishes a direction and never emits.
  always_comb begin
    new_evt  = 1'b0;
    new_code = EVT_WRAP_UP;
    if (classify && (state != SYNC)) begin
      if (is_jump) begin
        new_evt  = 1'b1;
        new_code = EVT_JUMP;
      end else if (dir_change) begin
        new_evt  = 1'b1;
        new_code = EVT_DIR_CHANGE;
      end else if (wrap_up) begin
        new_evt  = 1'b1;
        new_code = EVT_WRAP_UP;
      end else if (wrap_down) begin
        new_evt  = 1'b1;
        new_code = EVT_WRAP_DOWN;
      end
    end
  end

  assign dir = state;

  // Handshake: an event is transferred on a cycle with evt_valid=1 and
  // evt_ready=1; while valid and not ready the payload holds, and a new event
  // arriving then is dropped (sticky overflow). A new event may load in the
  // same cycle the pending one is accepted.
  assign load = new_evt && (!evt_valid || evt_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev           <= '0;
      prev_valid     <= 1'b0;
      last_dir_valid <= 1'b0;
      last_dir_down  <= 1'b0;
      wraps          <= '0;
      evt_valid      <= 1'b0;
      evt_code       <= EVT_WRAP_UP;
      evt_wraps      <= '0;
      overflow       <= 1'b0;
    end else begin
      prev       <= count;
      prev_valid <= 1'b1;
      wraps      <= wraps_next;
      if (classify && (is_up || is_down)) begin
        last_dir_valid <= 1'b1;
        last_dir_down  <= is_down;
      end
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= new_code;
        evt_wraps <= wraps_next;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (new_evt && evt_valid && !evt_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_tracker.sv
// Directed bench for count_tracker; expected events are queued as samples are
// driven and compared when the DUT hands them over.
module tb_count_tracker;

  localparam int WIDTH  = 5;
  localparam int WRAP_W = 8;
  localparam int W      = 2 + WRAP_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [WIDTH-1:0]  count = '0;
  logic              evt_ready = 1'b1;
  logic              evt_valid;
  logic [1:0]        evt_code;
  logic [WRAP_W-1:0] evt_wraps;
  logic [1:0]        dir;
  logic              overflow;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  count_tracker #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_wraps (evt_wraps),
    .dir       (dir),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 16'(evt_valid), 16'd0);
    chk("rst_code", 16'(evt_code), 16'd0);
    chk("rst_wraps", 16'(evt_wraps), 16'd0);
    chk("rst_dir", 16'(dir), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Drive one sample; compare any event accepted at the coming edge, then
  // check latency and queue the event this sample should raise.
  task automatic drive(input logic [WIDTH-1:0] c, input logic r, input logic push,
                       input logic [1:0] code, input logic [WRAP_W-1:0] wr);
    logic [W-1:0] e;
    count = c;
    evt_ready = r;
    #1;
    if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_evt", 16'(evt_valid), 16'd0);
      end else begin
        e = exp_q.pop_front();
        chk("evt_code", 16'(evt_code), 16'(e[W-1:WRAP_W]));
        chk("evt_wraps", 16'(evt_wraps), 16'(e[WRAP_W-1:0]));
      end
    end
    @(posedge clk); #1;
    if (push) begin
      chk("latency", 16'(evt_valid), 16'd1);
      exp_q.push_back({code, wr});
    end else if (r) begin
      chk("no_evt", 16'(evt_valid), 16'd0);
    end
  endtask

  task automatic go(input logic [WIDTH-1:0] c);
    drive(c, 1'b1, 1'b0, 2'b00, '0);
  endtask

  task automatic ev(input logic [WIDTH-1:0] c, input logic [1:0] code, input logic [WRAP_W-1:0] wr);
    drive(c, 1'b1, 1'b1, code, wr);
  endtask

  initial begin
    // Wrap-up ramp
    do_reset();
    go(5'd28);
    chk("s1_sync", 16'(dir), 16'd0);
    go(5'd29);
    chk("s1_up", 16'(dir), 16'd1);
    go(5'd30);
    go(5'd31);
    ev(5'd0, 2'b00, 8'd1);
    go(5'd1);
    chk("s1_up_after", 16'(dir), 16'd1);
    go(5'd1);
    chk("s1_hold", 16'(dir), 16'd3);
    chk("s1_drained", 16'(exp_q.size()), 16'd0);

    // Wrap-down ramp
    do_reset();
    go(5'd2);
    go(5'd1);
    chk("s2_down", 16'(dir), 16'd2);
    go(5'd0);
    ev(5'd31, 2'b01, 8'd1);
    go(5'd30);
    chk("s2_down_after", 16'(dir), 16'd2);
    chk("s2_drained", 16'(exp_q.size()), 16'd0);

    // Direction change
    do_reset();
    go(5'd5);
    go(5'd6);
    go(5'd7);
    ev(5'd6, 2'b10, 8'd0);
    chk("s3_down", 16'(dir), 16'd2);
    go(5'd6);
    chk("s3_drained", 16'(exp_q.size()), 16'd0);

    // Hold then resume, no events
    do_reset();
    go(5'd10);
    go(5'd11);
    go(5'd11);
    chk("s4_hold1", 16'(dir), 16'd3);
    go(5'd11);
    chk("s4_hold2", 16'(dir), 16'd3);
    go(5'd12);
    chk("s4_up", 16'(dir), 16'd1);

    // Backpressure: first event held, later one dropped, sticky overflow
    do_reset();
    drive(5'd30, 1'b0, 1'b0, 2'b00, '0);
    drive(5'd31, 1'b0, 1'b0, 2'b00, '0);
    drive(5'd0, 1'b0, 1'b1, 2'b00, 8'd1);
    chk("s5_no_ovf_yet", 16'(overflow), 16'd0);
    drive(5'd31, 1'b0, 1'b0, 2'b00, '0);
    chk("s5_ovf", 16'(overflow), 16'd1);
    chk("s5_hold_valid", 16'(evt_valid), 16'd1);
    chk("s5_hold_code", 16'(evt_code), 16'd0);
    chk("s5_hold_wraps", 16'(evt_wraps), 16'd1);
    chk("s5_dir", 16'(dir), 16'd2);
    drive(5'd31, 1'b0, 1'b0, 2'b00, '0);
    chk("s5_hold_code2", 16'(evt_code), 16'd0);
    go(5'd31);
    chk("s5_ovf_sticky", 16'(overflow), 16'd1);
    go(5'd30);
    chk("s5_ovf_sticky2", 16'(overflow), 16'd1);
    chk("s5_dir2", 16'(dir), 16'd2);
    chk("s5_drained", 16'(exp_q.size()), 16'd0);

    // Reset mid-handshake, first post-reset sample not classified
    do_reset();
    drive(5'd30, 1'b0, 1'b0, 2'b00, '0);
    drive(5'd31, 1'b0, 1'b0, 2'b00, '0);
    drive(5'd0, 1'b0, 1'b1, 2'b00, 8'd1);
    do_reset();
    go(5'd31);
    chk("s6_sync", 16'(dir), 16'd0);
    go(5'd0);
    chk("s6_up", 16'(dir), 16'd1);
    go(5'd1);
    ev(5'd0, 2'b10, 8'd1);
    ev(5'd31, 2'b01, 8'd2);
    go(5'd31);
    chk("s6_hold", 16'(dir), 16'd3);
    chk("s6_drained", 16'(exp_q.size()), 16'd0);

    // Jump
    do_reset();
    go(5'd3);
    go(5'd4);
`ifdef COUNT_TRACKER_JUMP_CHECK_EN
    ev(5'd20, 2'b11, 8'd0);
    chk("s7_jump_dir", 16'(dir), 16'd1);
`else
    go(5'd20);
    chk("s7_jump_dir", 16'(dir), 16'd3);
`endif
    go(5'd20);
    chk("s7_hold", 16'(dir), 16'd3);
    chk("s7_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/count_tracker.md
COUNT_TRACKER -- requirements
Module: count_tracker

Interface
REQ-001 Parameter WIDTH, default 5, SHALL set the width of the observed counter value.
REQ-002 Parameter WRAP_W, default 8, SHALL set the width of the wrap tally.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 count  input  WIDTH  SHALL be the value from the upstream up/down counter, sampled every cycle.
REQ-006 evt_valid  output  1  SHALL flag that an event is pending.
REQ-007 evt_ready  input  1  SHALL be the consumer's acceptance of the pending event.
REQ-008 evt_code  output  2  SHALL identify the event: 00 wrap-up, 01 wrap-down, 10 direction change, 11 jump.
REQ-009 evt_wraps  output  WRAP_W  SHALL be the wrap tally, captured when the event is loaded.
REQ-010 dir  output  2  SHALL give the FSM state: 00 SYNC, 01 UP, 10 DOWN, 11 HOLD.
REQ-011 overflow  output  1  SHALL be a sticky flag set when an event is dropped.

Function
REQ-012 Register prev SHALL capture count every cycle; d = (count - prev) mod 2^WIDTH.
REQ-013 Step classes SHALL be: d==1 up-step, d==2^WIDTH-1 down-step, d==0 hold, otherwise jump.
REQ-014 Wrap-up SHALL be prev==2^WIDTH-1 with count==0; wrap-down SHALL be prev==0 with count==2^WIDTH-1.
REQ-015 FSM transitions SHALL be:
- SYNC to UP/DOWN/HOLD per the first classified step; no event from SYNC.
- UP/DOWN/HOLD to UP on up-step, to DOWN on down-step, to HOLD on hold.
- Jump SHALL leave the state unchanged.
REQ-016 Register last_dir SHALL hold the most recent UP/DOWN step direction; HOLD SHALL NOT change it.
REQ-017 Direction change SHALL be a step whose direction differs from last_dir while last_dir is valid.
REQ-018 The wrap tally SHALL increment on every wrap, modulo 2^WRAP_W, whether or not the wrap event is emitted.
REQ-019 When several events coincide in one cycle, only one SHALL be emitted, priority jump > direction change > wrap.
REQ-020 An event SHALL appear on evt_valid the cycle after the count sample that caused it; latency is 1 cycle.
REQ-021 While evt_valid=1 and evt_ready=0, evt_code and evt_wraps SHALL hold stable.
REQ-022 evt_valid SHALL clear after a cycle with evt_valid=1 and evt_ready=1, unless a new event loads in that same cycle.
REQ-023 A new event arriving with evt_valid=1 and evt_ready=0 SHALL be dropped and SHALL set overflow.
REQ-024 A new event arriving with evt_valid=1 and evt_ready=1 SHALL load with no drop.

Reset
REQ-025 Reset SHALL force: state SYNC, prev 0, last_dir invalid, wrap tally 0, evt_valid 0, evt_code 00, evt_wraps 0, overflow 0.
REQ-026 Reset mid-handshake SHALL discard the pending event; the first post-reset cycle SHALL re-enter SYNC without classifying the count sample taken in that cycle.
REQ-027 Only reset SHALL clear overflow.

Configuration
REQ-028 With macro COUNT_TRACKER_JUMP_CHECK_EN defined, jump SHALL be classified and emitted as code 11.
REQ-029 Without COUNT_TRACKER_JUMP_CHECK_EN, a jump SHALL be treated as hold: state HOLD, no event; code 11 SHALL never be emitted.

Structure
REQ-030 Package count_pkg SHALL hold the state enum (SYNC/UP/DOWN/HOLD) and the evt_code constants.
REQ-031 Sub-module count_step_classify SHALL be purely combinational: prev and count in, step class and wrap flags out.

Verification
REQ-032 Reset 1 cycle, count ramps 28,29,30,31,0,1 with evt_ready=1 -> after SYNC, state UP; one event code 00 with evt_wraps=1, exactly one cycle after count=0.
REQ-033 Count 2,1,0,31,30 with evt_ready=1 -> state DOWN; event code 01 with evt_wraps=1.
REQ-034 Count 5,6,7,6 -> event code 10 one cycle after the 6 following 7; state DOWN.
REQ-035 Count 10,11,11,11,12 -> state HOLD during the repeats, then UP; no event.
REQ-036 evt_ready=0 held; ramp 30,31,0,31 -> first event (00) stays pending; the later direction change is dropped; overflow=1 and stays 1 until reset.
REQ-037 Count 3,4,20 -> code 11 with COUNT_TRACKER_JUMP_CHECK_EN defined; state HOLD and no event without it.
